control_fsm: RTL and testbench

- Multi-cycle control unit for the RV32I-subset datapath.
- Consumes the decoded instruction word and the ALU status flags from the datapath.
- Sequences the datapath through fetch, decode, execute, memory and writeback, driving every datapath select and enable line.
- Adds a PC write enable, a retired-instruction counter and an illegal-instruction halt.

---
 rtl/control_fsm.sv | 181 ++++++++++++++++++
 tb/tb_control_fsm.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_fsm.sv
// Multi-cycle control unit for the RV32I-subset datapath: walks fetch/decode/execute/
// memory/writeback, drives every datapath select and enable, counts retired instructions.
module control_fsm #(
    parameter int MEM_WAIT = 0,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      instr,
    input  logic [3:0]       status,
    output logic             pcsrc,
    output logic             pc_we,
    output logic             alusrc,
    output logic [3:0]       aluop,
    output logic             mrw,
    output logic             wb,
    output logic             regrw,
    output logic [1:0]       immgen_ctrl,
    output logic [2:0]       state,
    output logic             illegal,
    output logic [CNT_W-1:0] retire_cnt
);
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WBACK  = 3'd4,
        S_HALT   = 3'd7
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [3:0] WAIT_INIT = 4'(MEM_WAIT);

    state_t           state_q, state_d;
    logic [31:0]      ir_q, ir_d;
    logic [3:0]       wait_q, wait_d;
    logic [CNT_W-1:0] retire_q, retire_d;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       is_r, is_ialu, is_load, is_store, is_branch;
    logic       br_legal, br_taken, mem_done, in_datapath;
    logic       unused_bits;

    assign opcode      = ir_q[6:0];
    assign funct3      = ir_q[14:12];
    assign is_r        = (opcode == OP_R);
    assign is_ialu     = (opcode == OP_IALU);
    assign is_load     = (opcode == OP_LOAD);
    assign is_store    = (opcode == OP_STORE);
    assign is_branch   = (opcode == OP_BRANCH);
    assign mem_done    = (wait_q == 4'd0);
    assign in_datapath = (state_q == S_EXEC) || (state_q == S_MEM) || (state_q == S_WBACK);
    assign unused_bits = ^{ir_q[31], ir_q[29:15], ir_q[11:7], status[1]};

    // Branches are resolved from the flags of rs1 - rs2; only these four compares are supported.
    always_comb begin
        br_legal = 1'b1;
        br_taken = 1'b0;
        case (funct3)
            3'b000:  br_taken = status[2];
            3'b001:  br_taken = !status[2];
            3'b100:  br_taken = status[3] ^ status[0];
            3'b101:  br_taken = !(status[3] ^ status[0]);
            default: br_legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        ir_d     = ir_q;
        wait_d   = wait_q;
        retire_d = retire_q;
        case (state_q)
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                ir_d = instr;
                case (instr[6:0])
                    OP_R, OP_IALU, OP_LOAD, OP_STORE, OP_BRANCH: state_d = S_EXEC;
                    default:                                     state_d = S_HALT;
                endcase
            end
            S_EXEC: begin
                if (is_branch) begin
                    if (br_legal) begin
                        retire_d = retire_q + CNT_W'(1);
                        state_d  = S_FETCH;
                    end else begin
                        state_d = S_HALT;
                    end
                end else if (is_load || is_store) begin
                    wait_d  = WAIT_INIT;
                    state_d = S_MEM;
                end else begin
                    state_d = S_WBACK;
                end
            end
            S_MEM: begin
                if (!mem_done) begin
                    wait_d = wait_q - 4'd1;
                end else if (is_store) begin
                    retire_d = retire_q + CNT_W'(1);
                    state_d  = S_FETCH;
                end else begin
                    state_d = S_WBACK;
                end
            end
            S_WBACK: begin
                retire_d = retire_q + CNT_W'(1);
                state_d  = S_FETCH;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_HALT;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_FETCH;
            ir_q     <= '0;
            wait_q   <= '0;
            retire_q <= '0;
        end else begin
            state_q  <= state_d;
            ir_q     <= ir_d;
            wait_q   <= wait_d;
            retire_q <= retire_d;
        end
    end

    // Datapath selects come from the latched instruction; PC update is Mealy on the exit cycle.
    always_comb begin
        pcsrc       = 1'b0;
        pc_we       = 1'b0;
        alusrc      = 1'b0;
        aluop       = 4'b0000;
        mrw         = 1'b0;
        wb          = 1'b0;
        regrw       = 1'b0;
        immgen_ctrl = 2'b00;
        if (in_datapath) begin
            if (is_r) begin
                aluop = {ir_q[30], funct3};
                wb    = 1'b1;
            end else if (is_ialu) begin
                aluop  = (funct3 == 3'b101 && ir_q[30]) ? 4'b1101 : {1'b0, funct3};
                alusrc = 1'b1;
                wb     = 1'b1;
            end else if (is_load) begin
                alusrc = 1'b1;
            end else if (is_store) begin
                alusrc      = 1'b1;
                immgen_ctrl = 2'b01;
            end else if (is_branch) begin
                aluop       = 4'b1000;
                immgen_ctrl = 2'b10;
            end
        end
        if (state_q == S_EXEC && is_branch && br_legal) begin
            pc_we = 1'b1;
            pcsrc = br_taken;
        end
        if (state_q == S_MEM && is_store) begin
            mrw   = 1'b1;
            pc_we = mem_done;
        end
        if (state_q == S_WBACK) begin
            regrw = 1'b1;
            pc_we = 1'b1;
        end
    end

    assign state      = state_q;
    assign illegal    = (state_q == S_HALT);
    assign retire_cnt = retire_q;
endmodule

// File: tb/tb_control_fsm.sv
// Bench for control_fsm: hand-derived instruction table, corner sequences, and random
// instructions checked cycle by cycle against an instruction-level schedule model.
module tb_control_fsm;
    logic        clk;
    logic        rst_v [2];
    logic [31:0] ins_v [2];
    logic [3:0]  sts_v [2];
    logic [15:0] obs   [2];
    logic [15:0] ret   [2];

    logic        pcsrc0, pcwe0, alusrc0, mrw0, wb0, regrw0, ill0;
    logic [3:0]  aluop0;
    logic [1:0]  imm0;
    logic [2:0]  st0;
    logic [15:0] rc0;
    logic        pcsrc1, pcwe1, alusrc1, mrw1, wb1, regrw1, ill1;
    logic [3:0]  aluop1;
    logic [1:0]  imm1;
    logic [2:0]  st1;
    logic [1:0]  rc1;

    control_fsm #(.MEM_WAIT(0), .CNT_W(16)) dut0 (
        .clk(clk), .reset(rst_v[0]), .instr(ins_v[0]), .status(sts_v[0]),
        .pcsrc(pcsrc0), .pc_we(pcwe0), .alusrc(alusrc0), .aluop(aluop0), .mrw(mrw0),
        .wb(wb0), .regrw(regrw0), .immgen_ctrl(imm0), .state(st0), .illegal(ill0),
        .retire_cnt(rc0)
    );
    control_fsm #(.MEM_WAIT(2), .CNT_W(2)) dut1 (
        .clk(clk), .reset(rst_v[1]), .instr(ins_v[1]), .status(sts_v[1]),
        .pcsrc(pcsrc1), .pc_we(pcwe1), .alusrc(alusrc1), .aluop(aluop1), .mrw(mrw1),
        .wb(wb1), .regrw(regrw1), .immgen_ctrl(imm1), .state(st1), .illegal(ill1),
        .retire_cnt(rc1)
    );

    // Observed word layout: {state, illegal, pcsrc, pc_we, alusrc, aluop, mrw, wb, regrw, imm}
    assign obs[0] = {st0, ill0, pcsrc0, pcwe0, alusrc0, aluop0, mrw0, wb0, regrw0, imm0};
    assign obs[1] = {st1, ill1, pcsrc1, pcwe1, alusrc1, aluop1, mrw1, wb1, regrw1, imm1};
    assign ret[0] = rc0;
    assign ret[1] = {14'd0, rc1};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          vectors = 0;
    int          miscompares = 0;
    int          exp_ret [2];
    int          mw [2] = '{0, 2};
    int          cw [2] = '{16, 2};
    logic [15:0] exp_q [$];

    typedef struct {
        string       name;
        logic [31:0] ins;
        logic [3:0]  st;
        int          dut;
        int          cyc;
        logic [15:0] last;
    } vec_t;
    vec_t tbl [16];

    function automatic logic [15:0] rec(input int s, input int ill, input int pcs, input int pcw,
                                        input int asrc, input int aop, input int mrw,
                                        input int wbv, input int rgw, input int imm);
        return {3'(s), 1'(ill), 1'(pcs), 1'(pcw), 1'(asrc), 4'(aop), 1'(mrw), 1'(wbv),
                1'(rgw), 2'(imm)};
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %h want %h", nm, got, want);
        end
    endtask

    task automatic chk_ret(input int d, input string nm);
        chk($sformatf("%s retire d%0d", nm, d), 32'(ret[d]), 32'(exp_ret[d] % (1 << cw[d])));
    endtask

    // Entered and left just after a rising edge; leaves the DUT in its FETCH cycle.
    task automatic do_reset(input int d);
        rst_v[d] = 1'b1;
        #1;
        chk($sformatf("reset outputs d%0d", d), 32'(obs[d]), 32'd0);
        chk($sformatf("reset retire d%0d", d), 32'(ret[d]), 32'd0);
        exp_ret[d] = 0;
        @(posedge clk);
        #1;
        rst_v[d] = 1'b0;
    endtask

    // Instruction-level schedule: the cycle-by-cycle output word list one instruction produces.
    task automatic build_exp(input logic [31:0] ins, input logic [3:0] st, input int wt,
                             output bit halts);
        int op, f3, aop, asrc, wbv, imm, taken, n, z, v;
        op = int'(ins[6:0]);
        f3 = int'(ins[14:12]);
        n = int'(st[3]);
        z = int'(st[2]);
        v = int'(st[0]);
        aop = 0; asrc = 0; wbv = 0; imm = 0; taken = 0; halts = 0;
        exp_q.delete();
        exp_q.push_back(rec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        exp_q.push_back(rec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        if (op == 'h33) begin
            aop = int'(ins[30]) * 8 + f3; wbv = 1;
        end else if (op == 'h13) begin
            aop = (f3 == 5 && ins[30]) ? 13 : f3; asrc = 1; wbv = 1;
        end else if (op == 'h03) begin
            asrc = 1;
        end else if (op == 'h23) begin
            asrc = 1; imm = 1;
        end else if (op == 'h63) begin
            aop = 8; imm = 2;
            case (f3)
                0: taken = z;
                1: taken = 1 - z;
                4: taken = n ^ v;
                5: taken = 1 - (n ^ v);
                default: halts = 1;
            endcase
        end else begin
            halts = 1;
        end
        if (op == 'h33 || op == 'h13) begin
            exp_q.push_back(rec(2, 0, 0, 0, asrc, aop, 0, wbv, 0, imm));
            exp_q.push_back(rec(4, 0, 0, 1, asrc, aop, 0, wbv, 1, imm));
        end else if (op == 'h03) begin
            exp_q.push_back(rec(2, 0, 0, 0, 1, 0, 0, 0, 0, 0));
            for (int i = 0; i <= wt; i++) exp_q.push_back(rec(3, 0, 0, 0, 1, 0, 0, 0, 0, 0));
            exp_q.push_back(rec(4, 0, 0, 1, 1, 0, 0, 0, 1, 0));
        end else if (op == 'h23) begin
            exp_q.push_back(rec(2, 0, 0, 0, 1, 0, 0, 0, 0, 1));
            for (int i = 0; i < wt; i++) exp_q.push_back(rec(3, 0, 0, 0, 1, 0, 1, 0, 0, 1));
            exp_q.push_back(rec(3, 0, 0, 1, 1, 0, 1, 0, 0, 1));
        end else if (op == 'h63) begin
            exp_q.push_back(rec(2, 0, taken, halts ? 0 : 1, 0, 8, 0, 0, 0, 2));
        end
        if (halts) begin
            for (int i = 0; i < 20; i++) exp_q.push_back(rec(7, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        end
    endtask

    task automatic run_model(input int d, input logic [31:0] ins, input logic [3:0] st);
        bit          halts;
        int          c;
        logic [15:0] e;
        build_exp(ins, st, mw[d], halts);
        ins_v[d] = ins;
        sts_v[d] = st;
        c = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            @(negedge clk);
            chk($sformatf("d%0d ins %h st %h cyc%0d", d, ins, st, c), 32'(obs[d]), 32'(e));
            c++;
            @(posedge clk);
            #1;
        end
        if (halts) begin
            do_reset(d);
        end else begin
            exp_ret[d]++;
            chk_ret(d, $sformatf("ins %h", ins));
        end
    endtask

    // Runs one instruction until pc_we (bounded), checks cycle count and the pc_we-cycle word.
    task automatic run_vec(input int d, input logic [31:0] ins, input logic [3:0] st,
                           input int want_cyc, input logic [15:0] want_last, input string nm);
        int          ncyc;
        logic [15:0] last;
        ncyc = 0;
        last = '0;
        ins_v[d] = ins;
        sts_v[d] = st;
        for (int c = 1; c <= 30 && ncyc == 0; c++) begin
            @(negedge clk);
            if (obs[d][10]) begin
                ncyc = c;
                last = obs[d];
            end
            @(posedge clk);
            #1;
        end
        chk($sformatf("%s cycles", nm), 32'(ncyc), 32'(want_cyc));
        chk($sformatf("%s pc_we word", nm), 32'(last), 32'(want_last));
        if (ncyc == 0) begin
            do_reset(d);
        end else begin
            exp_ret[d]++;
            chk_ret(d, nm);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          cur;
        int          k;
        logic [31:0] rins;
        logic [3:0]  rst4;

        rst_v[0] = 1'b1; rst_v[1] = 1'b1;
        ins_v[0] = '0;   ins_v[1] = '0;
        sts_v[0] = '0;   sts_v[1] = '0;
        exp_ret[0] = 0;  exp_ret[1] = 0;

        tbl[0]  = '{"addi", 32'h00500093, 4'h0, 0, 4, rec(4, 0, 0, 1, 1, 0, 0, 1, 1, 0)};
        tbl[1]  = '{"sub",  32'h402081B3, 4'h0, 0, 4, rec(4, 0, 0, 1, 0, 8, 0, 1, 1, 0)};
        tbl[2]  = '{"add",  32'h002081B3, 4'h0, 0, 4, rec(4, 0, 0, 1, 0, 0, 0, 1, 1, 0)};
        tbl[3]  = '{"srai", 32'h40515093, 4'h0, 0, 4, rec(4, 0, 0, 1, 1, 13, 0, 1, 1, 0)};
        tbl[4]  = '{"sw0",  32'h00512623, 4'h0, 0, 4, rec(3, 0, 0, 1, 1, 0, 1, 0, 0, 1)};
        tbl[5]  = '{"lw0",  32'h00812283, 4'h0, 0, 5, rec(4, 0, 0, 1, 1, 0, 0, 0, 1, 0)};
        tbl[6]  = '{"beq_z",  32'h00208463, 4'h4, 0, 3, rec(2, 0, 1, 1, 0, 8, 0, 0, 0, 2)};
        tbl[7]  = '{"beq_nz", 32'h00208463, 4'h0, 0, 3, rec(2, 0, 0, 1, 0, 8, 0, 0, 0, 2)};
        tbl[8]  = '{"bne_z",  32'h00209463, 4'h4, 0, 3, rec(2, 0, 0, 1, 0, 8, 0, 0, 0, 2)};
        tbl[9]  = '{"bne_nz", 32'h00209463, 4'h0, 0, 3, rec(2, 0, 1, 1, 0, 8, 0, 0, 0, 2)};
        tbl[10] = '{"blt_n",  32'h0020C463, 4'h8, 0, 3, rec(2, 0, 1, 1, 0, 8, 0, 0, 0, 2)};
        tbl[11] = '{"blt_nv", 32'h0020C463, 4'h9, 0, 3, rec(2, 0, 0, 1, 0, 8, 0, 0, 0, 2)};
        tbl[12] = '{"bge_v",  32'h0020D463, 4'h1, 0, 3, rec(2, 0, 0, 1, 0, 8, 0, 0, 0, 2)};
        tbl[13] = '{"bge_0",  32'h0020D463, 4'h0, 0, 3, rec(2, 0, 1, 1, 0, 8, 0, 0, 0, 2)};
        tbl[14] = '{"lw2",  32'h00812283, 4'h0, 1, 7, rec(4, 0, 0, 1, 1, 0, 0, 0, 1, 0)};
        tbl[15] = '{"sw2",  32'h00512623, 4'h0, 1, 6, rec(3, 0, 0, 1, 1, 0, 1, 0, 0, 1)};

        @(posedge clk);
        #1;
        cur = -1;
        for (int i = 0; i < 16; i++) begin
            if (tbl[i].dut != cur) begin
                cur = tbl[i].dut;
                do_reset(cur);
            end
            run_vec(tbl[i].dut, tbl[i].ins, tbl[i].st, tbl[i].cyc, tbl[i].last, tbl[i].name);
        end

        // Illegal opcode halts for 20 cycles with pc_we low, then reset recovers it.
        do_reset(0);
        run_model(0, 32'hFFFFFFFF, 4'h0);
        run_vec(0, 32'h00500093, 4'h0, 4, rec(4, 0, 0, 1, 1, 0, 0, 1, 1, 0), "addi after halt");

        // Reset during the MEM cycle of a store drops mrw at once.
        ins_v[0] = 32'h00512623;
        sts_v[0] = 4'h0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        chk("store in MEM", 32'(obs[0]), 32'(rec(3, 0, 0, 1, 1, 0, 1, 0, 0, 1)));
        rst_v[0] = 1'b1;
        #1;
        chk("reset drops store", 32'(obs[0]), 32'd0);
        @(posedge clk);
        #1;
        rst_v[0] = 1'b0;
        exp_ret[0] = 0;
        chk_ret(0, "after store abort");
        run_vec(0, 32'h002081B3, 4'h0, 4, rec(4, 0, 0, 1, 0, 0, 0, 1, 1, 0), "add after abort");

        // Two-bit retire counter wraps 3 -> 0.
        do_reset(1);
        for (int i = 0; i < 4; i++)
            run_vec(1, 32'h00500093, 4'h0, 4, rec(4, 0, 0, 1, 1, 0, 0, 1, 1, 0), "addi wrap");
        chk("retire wrap", 32'(ret[1]), 32'd0);

        for (int d = 0; d < 2; d++) begin
            do_reset(d);
            for (int n = 0; n < 60; n++) begin
                k = $urandom_range(0, 9);
                rins = $urandom;
                rst4 = 4'($urandom_range(0, 15));
                case (k)
                    0, 1:    rins[6:0] = 7'b0110011;
                    2, 3:    rins[6:0] = 7'b0010011;
                    4:       rins[6:0] = 7'b0000011;
                    5:       rins[6:0] = 7'b0100011;
                    6, 7:    rins[6:0] = 7'b1100011;
                    8:       rins[6:0] = 7'($urandom_range(0, 127));
                    default: begin
                        rins[6:0] = 7'b0010011;
                        rins[14:12] = 3'b101;
                    end
                endcase
                run_model(d, rins, rst4);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
